// File: rtl/ga20_pkg.sv
// Shared types and constants for the GA20 sample fetch arbiter.
package ga20_pkg;

    localparam int unsigned ADDR_W   = 20;
    localparam logic [7:0]  FILL_DEF = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after (last + 1) mod NCH.
module rr_pick #(
    parameter int unsigned NCH = 4,
    parameter int unsigned GW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [GW-1:0]  last,
    output logic [GW-1:0]  grant,
    output logic           any_req
);

    int unsigned   idx;
    logic [GW-1:0] idx_g;
    logic          found;

    // Offset NCH wraps back to 'last' itself, so a lone requester is re-granted.
    always_comb begin
        grant = last;
        found = 1'b0;
        idx   = 0;
        idx_g = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = 32'(last) + k;
            if (idx >= NCH) idx = idx - NCH;
            idx_g = GW'(idx);
            if (!found && req[idx_g]) begin
                grant = idx_g;
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/ga20_sample_arb.sv
// Round-robin arbiter that serialises GA20 channel sample-ROM byte fetches onto one
// sample-cache read port, with a per-fetch timeout that returns a fill byte.
module ga20_sample_arb
    import ga20_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [7:0]  FILL    = FILL_DEF,
    localparam int unsigned GW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic [NCH-1:0]              ch_req,
    input  logic [NCH-1:0][ADDR_W-1:0]  ch_addr,
    output logic [NCH-1:0]              ch_ack,
    output logic [7:0]                  ch_data,
    output logic                        sample_rd,
    output logic [ADDR_W-1:0]           sample_addr,
    input  logic                        sample_valid,
    input  logic [7:0]                  sample_din,
    output logic                        timeout_err,
    output logic [GW-1:0]               grant_dbg
);

    localparam logic [7:0] TLIM = 8'(TIMEOUT);

    state_e        state;
    logic [7:0]    tcnt;
    logic [GW-1:0] pick;
    logic          any_req;

    rr_pick #(
        .NCH (NCH),
        .GW  (GW)
    ) u_rr_pick (
        .req     (ch_req),
        .last    (grant_dbg),
        .grant   (pick),
        .any_req (any_req)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= StIdle;
            tcnt        <= '0;
            sample_rd   <= 1'b0;
            sample_addr <= '0;
            ch_ack      <= '0;
            ch_data     <= FILL;
            timeout_err <= 1'b0;
            grant_dbg   <= GW'(NCH - 1);
        end else begin
            ch_ack <= '0;
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        grant_dbg   <= pick;
                        sample_addr <= ch_addr[pick];
                        sample_rd   <= 1'b1;
                        tcnt        <= '0;
                        state       <= StIssue;
                    end
                end
                StIssue, StWait: begin
                    if (tcnt != TLIM) tcnt <= tcnt + 8'd1;
                    if (sample_valid || (state == StWait && tcnt == TLIM)) begin
                        sample_rd <= 1'b0;
                        state     <= StDone;
                        if (!sample_valid) timeout_err <= 1'b1;
                        // Withdrawal is judged on the completing edge so ack and data
                        // are both registered for the DONE cycle.
                        if (ch_req[grant_dbg]) begin
                            ch_ack[grant_dbg] <= 1'b1;
                            ch_data           <= sample_valid ? sample_din : FILL;
                        end
                    end else begin
                        state <= StWait;
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ga20_sample_arb.sv
// Self-checking bench for ga20_sample_arb: vector table, directed corner sequences,
// and a randomized run against a transaction-level round-robin model.
module tb_ga20_sample_arb;
    import ga20_pkg::*;

    localparam int unsigned NCH     = 4;
    localparam int unsigned TIMEOUT = 255;

    logic                       clk_sys = 1'b0;
    logic                       reset_n;
    logic [NCH-1:0]             ch_req;
    logic [NCH-1:0][ADDR_W-1:0] ch_addr;
    logic [NCH-1:0]             ch_ack;
    logic [7:0]                 ch_data;
    logic                       sample_rd;
    logic [ADDR_W-1:0]          sample_addr;
    logic                       sample_valid;
    logic [7:0]                 sample_din;
    logic                       timeout_err;
    logic [1:0]                 grant_dbg;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_sys = ~clk_sys;

    ga20_sample_arb #(
        .NCH     (NCH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ch_req       (ch_req),
        .ch_addr      (ch_addr),
        .ch_ack       (ch_ack),
        .ch_data      (ch_data),
        .sample_rd    (sample_rd),
        .sample_addr  (sample_addr),
        .sample_valid (sample_valid),
        .sample_din   (sample_din),
        .timeout_err  (timeout_err),
        .grant_dbg    (grant_dbg)
    );

    typedef struct {
        logic [NCH-1:0] req;
        int             d;
        logic [7:0]     din;
        int             exp_ch;
        int             exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        ch_req       = '0;
        sample_valid = 1'b0;
        sample_din   = '0;
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd"},    32'(sample_rd),   32'(0));
        chk({tag, "_ack"},   32'(ch_ack),      32'(0));
        chk({tag, "_terr"},  32'(timeout_err), 32'(0));
        chk({tag, "_data"},  32'(ch_data),     32'(8'h80));
        chk({tag, "_addr"},  32'(sample_addr), 32'(0));
        chk({tag, "_grant"}, 32'(grant_dbg),   32'(NCH - 1));
    endtask

    // Round-robin rule: first active requester at offsets 1..NCH after the last grant.
    function automatic int rr_next(input logic [NCH-1:0] req, input int last);
        for (int off = 1; off <= NCH; off++) begin
            int c;
            c = (last + off) % NCH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // One fetch: request raised in an idle cycle, cache answers d cycles after sample_rd
    // rises (d < 0: never). lat counts cycles inclusively from request to ack.
    task automatic fetch(input logic [NCH-1:0] req, input int d, input logic [7:0] din,
                         output logic [NCH-1:0] ack, output int lat,
                         output logic [ADDR_W-1:0] addr_iss, output logic [1:0] g_iss,
                         output logic [7:0] data);
        int k;
        bit seen;
        k = 0; seen = 0; lat = 1;
        ack = '0; addr_iss = '0; g_iss = '0; data = '0;
        ch_req = req;
        sample_valid = 1'b0;
        while (lat < 600) begin
            step();
            lat++;
            if (ch_ack != '0) begin
                ack  = ch_ack;
                data = ch_data;
                break;
            end
            if (sample_rd) begin
                if (!seen) begin
                    seen     = 1;
                    addr_iss = sample_addr;
                    g_iss    = grant_dbg;
                end
                sample_valid = (k == d);
                sample_din   = (k == d) ? din : 8'($urandom);
                k++;
            end else begin
                sample_valid = 1'b0;
            end
        end
        ch_req = '0;
        sample_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        vec_t              tbl[8];
        logic [NCH-1:0]    ack, exp_ack, req_prev;
        logic [NCH-1:0]    order[8];
        logic [ADDR_W-1:0] a_iss;
        logic [1:0]        g_iss;
        logic [7:0]        data, data_m, dat_exp;
        int                lat, n_ack, k, d, g_exp, last_m, wait_cnt;
        bit                busy, ack_due;

        tbl[0] = '{4'b0001, 2, 8'h5A, 0, 5};
        tbl[1] = '{4'b1111, 0, 8'h11, 1, 3};
        tbl[2] = '{4'b1001, 1, 8'h22, 3, 4};
        tbl[3] = '{4'b0110, 3, 8'hC3, 1, 6};
        tbl[4] = '{4'b0100, 0, 8'h00, 2, 3};
        tbl[5] = '{4'b0100, 1, 8'hFF, 2, 4};
        tbl[6] = '{4'b1000, 2, 8'h96, 3, 5};
        tbl[7] = '{4'b0001, 0, 8'h69, 0, 3};

        ch_addr[0] = 20'h12345;
        ch_addr[1] = 20'hABCDE;
        ch_addr[2] = 20'h0F00F;
        ch_addr[3] = 20'hFFFFF;

        do_reset();
        chk_reset_vals("reset");

        // Vector table: single fetches with hand-derived grant order and latency.
        for (int i = 0; i < 8; i++) begin
            step();
            fetch(tbl[i].req, tbl[i].d, tbl[i].din, ack, lat, a_iss, g_iss, data);
            exp_ack = '0;
            exp_ack[tbl[i].exp_ch] = 1'b1;
            chk($sformatf("vec%0d_ack", i),   32'(ack),   32'(exp_ack));
            chk($sformatf("vec%0d_data", i),  32'(data),  32'(tbl[i].din));
            chk($sformatf("vec%0d_lat", i),   32'(lat),   32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_addr", i),  32'(a_iss), 32'(ch_addr[tbl[i].exp_ch]));
            chk($sformatf("vec%0d_grant", i), 32'(g_iss), 32'(tbl[i].exp_ch));
        end

        // All four requesting continuously: strict rotation from channel 0.
        do_reset();
        for (int i = 0; i < 8; i++) order[i] = '0;
        ch_req = '1;
        n_ack = 0;
        for (int cyc = 0; cyc < 200 && n_ack < 8; cyc++) begin
            step();
            if (ch_ack != '0) begin
                order[n_ack] = ch_ack;
                n_ack++;
            end
            sample_valid = sample_rd;
            sample_din   = 8'(cyc);
        end
        ch_req = '0;
        sample_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_ack = '0;
            exp_ack[i % NCH] = 1'b1;
            chk($sformatf("rot%0d_ack", i), 32'(order[i]), 32'(exp_ack));
        end

        // Timeout: one ISSUE cycle, TIMEOUT wait cycles, then DONE with the fill byte.
        do_reset();
        step();
        fetch(4'b0001, -1, 8'h00, ack, lat, a_iss, g_iss, data);
        chk("tmo_ack",  32'(ack),         32'(4'b0001));
        chk("tmo_lat",  32'(lat),         32'(TIMEOUT + 3));
        chk("tmo_data", 32'(data),        32'(8'h80));
        chk("tmo_terr", 32'(timeout_err), 32'(1));
        step();
        fetch(4'b0010, 1, 8'h3C, ack, lat, a_iss, g_iss, data);
        chk("tmo_next_data", 32'(data),        32'(8'h3C));
        chk("tmo_sticky",    32'(timeout_err), 32'(1));

        // Channel 2 withdraws during WAIT; channel 3 must be granted next.
        do_reset();
        step();
        fetch(4'b0001, 0, 8'h33, ack, lat, a_iss, g_iss, data);
        step();
        fetch(4'b0010, 0, 8'h44, ack, lat, a_iss, g_iss, data);
        step();
        ch_req = 4'b1100;
        step();
        chk("wd_grant2", 32'(grant_dbg), 32'(2));
        chk("wd_rd",     32'(sample_rd), 32'(1));
        step();
        ch_req[2] = 1'b0;
        step();
        sample_valid = 1'b1;
        sample_din   = 8'hEE;
        step();
        sample_valid = 1'b0;
        chk("wd_noack",   32'(ch_ack),    32'(0));
        chk("wd_hold",    32'(ch_data),   32'(8'h44));
        chk("wd_rd_drop", 32'(sample_rd), 32'(0));
        step();
        chk("wd_noack2", 32'(ch_ack), 32'(0));
        step();
        chk("wd_grant3", 32'(grant_dbg),   32'(3));
        chk("wd_addr3",  32'(sample_addr), 32'(ch_addr[3]));
        sample_valid = 1'b1;
        sample_din   = 8'h77;
        step();
        sample_valid = 1'b0;
        ch_req = '0;
        chk("wd_ack3",  32'(ch_ack),  32'(4'b1000));
        chk("wd_data3", 32'(ch_data), 32'(8'h77));

        // Reset in WAIT, then a stray sample_valid after release.
        do_reset();
        ch_req = 4'b0001;
        step();
        step();
        chk("rst_inwait_rd", 32'(sample_rd), 32'(1));
        #2 reset_n = 1'b0;
        ch_req = '0;
        #1 chk_reset_vals("rst_async");
        step();
        step();
        reset_n = 1'b1;
        sample_valid = 1'b1;
        sample_din   = 8'h99;
        step();
        step();
        sample_valid = 1'b0;
        chk_reset_vals("rst_after");

        // Randomized traffic against a transaction-level model.
        do_reset();
        last_m = NCH - 1; busy = 0; ack_due = 0; data_m = 8'h80;
        wait_cnt = 0; k = 0; d = 0; g_exp = 0; dat_exp = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int dropped;
            step();
            req_prev = ch_req;
            dropped  = -1;
            exp_ack  = '0;
            if (ack_due) begin
                exp_ack[g_exp] = 1'b1;
                data_m = dat_exp;
            end
            chk("rand_ack",  32'(ch_ack),  32'(exp_ack));
            chk("rand_data", 32'(ch_data), 32'(data_m));
            if (ack_due) begin
                ch_req[g_exp] = 1'b0;
                dropped = g_exp;
                ack_due = 0;
                busy    = 0;
            end else if (sample_rd && !busy) begin
                g_exp = rr_next(req_prev, last_m);
                chk("rand_grant", 32'(grant_dbg), 32'(g_exp));
                if (g_exp < 0) g_exp = 0;
                chk("rand_addr", 32'(sample_addr), 32'(ch_addr[g_exp]));
                last_m  = g_exp;
                busy    = 1;
                k       = 0;
                d       = $urandom_range(0, 3);
                dat_exp = 8'($urandom);
            end
            if (!busy && req_prev != '0 && !sample_rd) wait_cnt++;
            else wait_cnt = 0;
            chk("rand_stall", 32'(wait_cnt > 3), 32'(0));
            if (busy) begin
                sample_valid = (k == d);
                sample_din   = (k == d) ? dat_exp : 8'($urandom);
                if (k == d) ack_due = 1;
                k++;
            end else begin
                sample_valid = 1'($urandom_range(0, 1));
                sample_din   = 8'($urandom);
            end
            for (int c = 0; c < NCH; c++) begin
                if (!ch_req[c] && c != dropped && $urandom_range(0, 3) == 0) begin
                    ch_addr[c] = 20'($urandom);
                    ch_req[c]  = 1'b1;
                end
            end
        end
        ch_req = '0;
        sample_valid = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
